// File: rtl/condicionador_botoes_pkg.sv
// Shared definitions for the button conditioner: FSM state encoding and the
// default debounce / combo-window lengths (in clock cycles).
package pkg_botoes;

    localparam int unsigned DEBOUNCE_CICLOS_PADRAO = 500000;
    localparam int unsigned JANELA_COMBO_PADRAO    = 2500000;

    typedef enum logic [1:0] {
        OCIOSO    = 2'b00,
        ESPERA_B1 = 2'b01,
        ESPERA_B2 = 2'b10,
        LIBERA    = 2'b11
    } estado_t;

endpackage

// File: rtl/condicionador_botoes_debounce.sv
// debounce_botao: synchroniser, debounce and press-edge detector for one button.
// Ports:
//   clk     - system clock
//   rst     - asynchronous, active-high reset
//   raw     - raw button pin (asynchronous)
//   estavel - debounced level, 1 = pressed
//   aperto  - one-cycle press event (rising edge of estavel)
module debounce_botao
    import pkg_botoes::*;
#(
    parameter int unsigned DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO,
    parameter bit          ATIVO_BAIXO     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic estavel,
    output logic aperto
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CICLOS) + 1;

    logic          p;
    logic          sinc1_q, sinc1_d;
    logic          sinc2_q, sinc2_d;
    logic          estavel_q, estavel_d;
    logic          atraso_q, atraso_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Normalise so that 1 always means pressed
    assign p = raw ^ ATIVO_BAIXO;

    // Next-state: a new level is accepted only after DEBOUNCE_CICLOS consecutive differing cycles
    always_comb begin
        sinc1_d   = p;
        sinc2_d   = sinc1_q;
        atraso_d  = estavel_q;
        estavel_d = estavel_q;
        cnt_d     = '0;
        if (sinc2_q != estavel_q) begin
            if (cnt_q == CW'(DEBOUNCE_CICLOS - 1)) begin
                estavel_d = sinc2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Everything resets to "pressed" so a button held through reset yields no event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sinc1_q   <= 1'b1;
            sinc2_q   <= 1'b1;
            estavel_q <= 1'b1;
            atraso_q  <= 1'b1;
            cnt_q     <= '0;
        end else begin
            sinc1_q   <= sinc1_d;
            sinc2_q   <= sinc2_d;
            estavel_q <= estavel_d;
            atraso_q  <= atraso_d;
            cnt_q     <= cnt_d;
        end
    end

    assign estavel = estavel_q;
    assign aperto  = estavel_q & ~atraso_q;

endmodule

// File: rtl/condicionador_botoes.sv
// condicionador_botoes: debounces two pet buttons and turns each user action
// into a single-cycle pulse, merging near-simultaneous presses into a combo.
// Ports:
//   clk     - system clock
//   rst     - asynchronous, active-high reset
//   btn1    - raw button 1 pin
//   btn2    - raw button 2 pin
//   b1      - one-cycle pulse for button 1 / combo
//   b2      - one-cycle pulse for button 2 / combo
//   ocupado - high whenever the FSM is not idle
module condicionador_botoes
    import pkg_botoes::*;
#(
    parameter int unsigned DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO,
    parameter int unsigned JANELA_COMBO    = JANELA_COMBO_PADRAO,
    parameter bit          ATIVO_BAIXO     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn1,
    input  logic btn2,
    output logic b1,
    output logic b2,
    output logic ocupado
);

    localparam int unsigned JW = $clog2(JANELA_COMBO) + 1;

    logic          estavel1, estavel2;
    logic          a1, a2;
    estado_t       estado_q, estado_d;
    logic [JW-1:0] janela_q, janela_d;
    logic          b1_q, b1_d;
    logic          b2_q, b2_d;
    logic          ocupado_q, ocupado_d;

    debounce_botao #(
        .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS),
        .ATIVO_BAIXO     (ATIVO_BAIXO)
    ) u_deb1 (
        .clk     (clk),
        .rst     (rst),
        .raw     (btn1),
        .estavel (estavel1),
        .aperto  (a1)
    );

    debounce_botao #(
        .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS),
        .ATIVO_BAIXO     (ATIVO_BAIXO)
    ) u_deb2 (
        .clk     (clk),
        .rst     (rst),
        .raw     (btn2),
        .estavel (estavel2),
        .aperto  (a2)
    );

    // Event FSM: wait a window for the other button, then pulse and hold in LIBERA until released
    always_comb begin
        estado_d = estado_q;
        janela_d = janela_q;
        b1_d     = 1'b0;
        b2_d     = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (a1 && a2) begin
                    b1_d     = 1'b1;
                    b2_d     = 1'b1;
                    estado_d = LIBERA;
                end else if (a1) begin
                    janela_d = '0;
                    estado_d = ESPERA_B1;
                end else if (a2) begin
                    janela_d = '0;
                    estado_d = ESPERA_B2;
                end
            end
            ESPERA_B1: begin
                if (a2) begin
                    b1_d     = 1'b1;
                    b2_d     = 1'b1;
                    estado_d = LIBERA;
                end else if (janela_q == JW'(JANELA_COMBO - 1)) begin
                    b1_d     = 1'b1;
                    estado_d = LIBERA;
                end else begin
                    janela_d = janela_q + JW'(1);
                end
            end
            ESPERA_B2: begin
                if (a1) begin
                    b1_d     = 1'b1;
                    b2_d     = 1'b1;
                    estado_d = LIBERA;
                end else if (janela_q == JW'(JANELA_COMBO - 1)) begin
                    b2_d     = 1'b1;
                    estado_d = LIBERA;
                end else begin
                    janela_d = janela_q + JW'(1);
                end
            end
            LIBERA: begin
                // Presses here are dropped, so a held button never repeats
                if (!estavel1 && !estavel2) begin
                    estado_d = OCIOSO;
                end
            end
            default: estado_d = LIBERA;
        endcase
        ocupado_d = (estado_d != OCIOSO);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q  <= LIBERA;
            janela_q  <= '0;
            b1_q      <= 1'b0;
            b2_q      <= 1'b0;
            ocupado_q <= 1'b1;
        end else begin
            estado_q  <= estado_d;
            janela_q  <= janela_d;
            b1_q      <= b1_d;
            b2_q      <= b2_d;
            ocupado_q <= ocupado_d;
        end
    end

    assign b1      = b1_q;
    assign b2      = b2_q;
    assign ocupado = ocupado_q;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Bench for condicionador_botoes with short debounce/window lengths and active-high pins.
module tb_condicionador_botoes;

    localparam int unsigned DEB = 4;
    localparam int unsigned JAN = 8;
    localparam int SOLO  = DEB + JAN + 2;   // press edge to solo pulse edge
    localparam int COMBO = DEB + 2;         // second press edge to combo pulse edge

    logic clk = 1'b0;
    logic rst;
    logic btn1, btn2;
    logic b1, b2, ocupado;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [1:0] kind;   // {b1, b2}
        int         cyc;
    } ev_t;

    ev_t sb[$];

    condicionador_botoes #(
        .DEBOUNCE_CICLOS (DEB),
        .JANELA_COMBO    (JAN),
        .ATIVO_BAIXO     (1'b0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn1    (btn1),
        .btn2    (btn2),
        .b1      (b1),
        .b2      (b2),
        .ocupado (ocupado)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic esperar(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic esperado(input logic [1:0] kind, input int c);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    // Scoreboard consumer: every pulse must match the next expected event
    always @(negedge clk) begin
        if (!rst && (b1 || b2)) begin
            if (sb.size() == 0) begin
                chk("pulso_inesperado", {30'd0, b1, b2}, 32'd0);
            end else begin
                ev_t e;
                e = sb.pop_front();
                chk("tipo_pulso", {30'd0, b1, b2}, {30'd0, e.kind});
                chk("ciclo_pulso", cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int r;
        rst  = 1'b1;
        btn1 = 1'b0;
        btn2 = 1'b0;

        // 1: reset behaviour and ocupado release timing
        repeat (3) begin
            @(negedge clk);
            chk("reset_b1", {31'd0, b1}, 32'd0);
            chk("reset_b2", {31'd0, b2}, 32'd0);
            chk("reset_ocupado", {31'd0, ocupado}, 32'd1);
        end
        rst = 1'b0;
        r = cyc;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            chk("ocupado_pos_reset", {31'd0, ocupado}, (cyc - r < 7) ? 32'd1 : 32'd0);
        end
        esperar(5);

        // 2: bouncing then stable hold on btn1 -> single solo pulse
        for (int i = 0; i < 10; i++) begin
            btn1 = (i % 2 == 0);
            esperar(1);
        end
        btn1 = 1'b1;
        k = cyc + 1;
        esperado(2'b10, k + SOLO);
        esperar(30);
        btn1 = 1'b0;
        esperar(20);
        chk("t2_fila", sb.size(), 32'd0);
        chk("t2_ocioso", {31'd0, ocupado}, 32'd0);

        // 3: btn2 three cycles after btn1 -> combo
        btn1 = 1'b1;
        esperar(3);
        btn2 = 1'b1;
        k = cyc + 1;
        esperado(2'b11, k + COMBO);
        esperar(30);
        btn1 = 1'b0;
        btn2 = 1'b0;
        esperar(20);
        chk("t3_fila", sb.size(), 32'd0);
        chk("t3_ocioso", {31'd0, ocupado}, 32'd0);

        // 4: simultaneous press -> combo; busy until both released
        btn1 = 1'b1;
        btn2 = 1'b1;
        k = cyc + 1;
        esperado(2'b11, k + COMBO);
        esperar(20);
        chk("t4_ocupado_ambos", {31'd0, ocupado}, 32'd1);
        btn1 = 1'b0;
        esperar(20);
        chk("t4_ocupado_b2", {31'd0, ocupado}, 32'd1);
        btn2 = 1'b0;
        esperar(20);
        chk("t4_fila", sb.size(), 32'd0);
        chk("t4_ocioso", {31'd0, ocupado}, 32'd0);

        // 5: second press after the window -> solo b1 only
        btn1 = 1'b1;
        k = cyc + 1;
        esperado(2'b10, k + SOLO);
        esperar(12);
        btn2 = 1'b1;
        esperar(30);
        chk("t5_ocupado", {31'd0, ocupado}, 32'd1);
        btn1 = 1'b0;
        btn2 = 1'b0;
        esperar(20);
        chk("t5_fila", sb.size(), 32'd0);
        chk("t5_ocioso", {31'd0, ocupado}, 32'd0);

        // 6: btn1 held through reset -> nothing until released and pressed again
        btn1 = 1'b1;
        esperar(2);
        rst = 1'b1;
        esperar(3);
        rst = 1'b0;
        esperar(20);
        chk("t6_ocupado_preso", {31'd0, ocupado}, 32'd1);
        chk("t6_fila_preso", sb.size(), 32'd0);
        btn1 = 1'b0;
        esperar(20);
        chk("t6_ocioso_solto", {31'd0, ocupado}, 32'd0);
        btn1 = 1'b1;
        k = cyc + 1;
        esperado(2'b10, k + SOLO);
        esperar(30);
        btn1 = 1'b0;
        esperar(20);
        chk("t6_fila", sb.size(), 32'd0);
        chk("t6_ocioso", {31'd0, ocupado}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
